// File: rtl/led_pwm_seq.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_seq
// Purpose  : Multi-channel LED PWM sequencer. Per-channel duty and a shared
//            mode (off / static / blink / breathe) are captured into shadow
//            registers on i_load and copied to the active registers only at a
//            PWM period boundary, so an LED never changes mid-period.
// Ports    : i_clk           system clock
//            i_rst_n         asynchronous active-low reset
//            i_load          one-cycle strobe capturing i_duty / i_mode
//            i_mode          0 off, 1 static, 2 blink, 3 breathe
//            i_duty          channel c duty in bits [c*W +: W]
//            o_led           registered active-high LED enables
//            o_period_strobe registered one-cycle pulse per period boundary
// Revision : 1.0  initial release
// ============================================================================
module led_pwm_seq #(
  parameter int CHANNELS      = 3,
  parameter int PWM_WIDTH     = 8,
  parameter int PRESCALE      = 1,
  parameter int BLINK_PERIODS = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_load,
  input  logic [1:0]                    i_mode,
  input  logic [CHANNELS*PWM_WIDTH-1:0] i_duty,
  output logic [CHANNELS-1:0]           o_led,
  output logic                          o_period_strobe
);

  localparam int W    = PWM_WIDTH;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_PERIODS - 1);
  localparam logic [W-1:0]    CNT_MAX = {W{1'b1}};

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [PS_W-1:0]         ps_q,        ps_d;
  logic [W-1:0]            cnt_q,       cnt_d;
  logic [CHANNELS*W-1:0]   sh_duty_q,   sh_duty_d;
  mode_e                   sh_mode_q,   sh_mode_d;
  logic [CHANNELS*W-1:0]   act_duty_q,  act_duty_d;
  mode_e                   act_mode_q,  act_mode_d;
  logic [W-1:0]            env_q,       env_d;
  logic                    dir_down_q,  dir_down_d;
  logic [BC_W-1:0]         blink_cnt_q, blink_cnt_d;
  logic                    phase_q,     phase_d;
  logic [CHANNELS-1:0]     led_q,       led_d;
  logic                    strobe_q,    strobe_d;

  logic                    tick;
  logic                    boundary;
  logic [W-1:0]            duty_c;
  logic [W-1:0]            eff_c;

  always_comb begin
    tick     = (ps_q == PS_LAST);
    boundary = tick && (cnt_q == CNT_MAX);

    ps_d        = tick ? '0 : ps_q + PS_W'(1);
    cnt_d       = tick ? cnt_q + W'(1) : cnt_q;
    sh_duty_d   = sh_duty_q;
    sh_mode_d   = sh_mode_q;
    act_duty_d  = act_duty_q;
    act_mode_d  = act_mode_q;
    env_d       = env_q;
    dir_down_d  = dir_down_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    strobe_d    = boundary;
    led_d       = '0;
    duty_c      = '0;
    eff_c       = '0;

    if (i_load) begin
      sh_duty_d = i_duty;
      sh_mode_d = mode_e'(i_mode);
    end

    // The active copy takes the shadow value held before this edge, so a
    // load landing on the boundary cycle waits one more period.
    if (boundary) begin
      act_duty_d = sh_duty_q;
      act_mode_d = sh_mode_q;
      if (sh_mode_q != act_mode_q) begin
        // A new mode always starts its animation from the beginning.
        env_d       = '0;
        dir_down_d  = 1'b0;
        blink_cnt_d = '0;
        phase_d     = 1'b1;
      end else begin
        case (act_mode_q)
          MODE_BLINK: begin
            if (blink_cnt_q == BC_LAST) begin
              blink_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BC_W'(1);
            end
          end
          MODE_BREATHE: begin
            // Triangle envelope: direction flips at the extremes so each
            // end value is held for exactly one period.
            if (env_q == CNT_MAX) begin
              dir_down_d = 1'b1;
              env_d      = env_q - W'(1);
            end else if (env_q == '0) begin
              dir_down_d = 1'b0;
              env_d      = env_q + W'(1);
            end else begin
              env_d = dir_down_q ? env_q - W'(1) : env_q + W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    for (int c = 0; c < CHANNELS; c++) begin
      duty_c = act_duty_q[c*W +: W];
      case (act_mode_q)
        MODE_STATIC:  eff_c = duty_c;
        MODE_BLINK:   eff_c = phase_q ? duty_c : '0;
        // Upper half of the 2W-bit product scales duty by env/2^W.
        MODE_BREATHE: eff_c = W'(({{W{1'b0}}, duty_c} * {{W{1'b0}}, env_q}) >> W);
        default:      eff_c = '0;
      endcase
      led_d[c] = (cnt_q < eff_c);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps_q        <= '0;
      cnt_q       <= '0;
      sh_duty_q   <= '0;
      sh_mode_q   <= MODE_OFF;
      act_duty_q  <= '0;
      act_mode_q  <= MODE_OFF;
      env_q       <= '0;
      dir_down_q  <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_q       <= '0;
      strobe_q    <= 1'b0;
    end else begin
      ps_q        <= ps_d;
      cnt_q       <= cnt_d;
      sh_duty_q   <= sh_duty_d;
      sh_mode_q   <= sh_mode_d;
      act_duty_q  <= act_duty_d;
      act_mode_q  <= act_mode_d;
      env_q       <= env_d;
      dir_down_q  <= dir_down_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      strobe_q    <= strobe_d;
    end
  end

  assign o_led           = led_q;
  assign o_period_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pwm_seq
// Purpose  : Self-checking bench for led_pwm_seq. Two instances share one
//            clock: an 8-bit, 3-channel, unprescaled one and a 4-bit,
//            1-channel, prescale-3 one. Expected per-period high counts are
//            queued alongside the stimulus and compared period by period.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_pwm_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load8, load4;
  logic [1:0]  mode8, mode4;
  logic [23:0] duty8;
  logic [3:0]  duty4;
  logic [2:0]  led8;
  logic [0:0]  led4;
  logic        strobe8, strobe4;

  always #5 clk = ~clk;

  led_pwm_seq #(.CHANNELS(3), .PWM_WIDTH(8), .PRESCALE(1), .BLINK_PERIODS(2)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load8), .i_mode(mode8), .i_duty(duty8),
    .o_led(led8), .o_period_strobe(strobe8)
  );

  led_pwm_seq #(.CHANNELS(1), .PWM_WIDTH(4), .PRESCALE(3), .BLINK_PERIODS(2)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load4), .i_mode(mode4), .i_duty(duty4),
    .o_led(led4), .o_period_strobe(strobe4)
  );

  // Selects which instance the period monitor observes.
  logic       sel;
  logic [2:0] w_led;
  logic       w_strobe;
  always_comb begin
    w_led    = sel ? {2'b00, led4} : led8;
    w_strobe = sel ? strobe4 : strobe8;
  end

  int          n_total = 0;
  int          n_bad   = 0;
  string       cur_test;
  logic [47:0] exp_q [$];   // {ch2, ch1, ch0} expected high cycles, 16 bits each

  task automatic chk(input string tag, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int h0, input int h1, input int h2);
    exp_q.push_back({16'(h2), 16'(h1), 16'(h0)});
  endtask

  task automatic sync_strobe();
    bit got = 0;
    for (int i = 0; i < 700 && !got; i++) begin
      @(negedge clk);
      if (w_strobe) got = 1;
    end
    chk({cur_test, " sync"}, int'(got), 1);
  endtask

  // Must start on the negedge where the strobe is seen. Each period window
  // is the plen cycles after it; the last one must carry the next strobe.
  // Optionally issues one load in period lp at window index li.
  task automatic run_periods(input int n, input int lp, input int li,
                             input logic [1:0] m, input logic [23:0] d);
    int          plen;
    int          hi [3];
    int          run [3];
    bit          low_seen [3];
    int          sc;
    logic        last_s;
    logic [47:0] ev;
    plen = sel ? 48 : 256;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 3; c++) begin
        hi[c] = 0; run[c] = 0; low_seen[c] = 0;
      end
      sc = 0;
      last_s = 1'b0;
      for (int i = 0; i < plen; i++) begin
        @(negedge clk);
        load8 = 1'b0;
        load4 = 1'b0;
        for (int c = 0; c < 3; c++) begin
          if (w_led[c]) begin
            hi[c]++;
            if (!low_seen[c]) run[c]++;
          end else begin
            low_seen[c] = 1;
          end
        end
        if (w_strobe) sc++;
        last_s = w_strobe;
        if (p == lp && i == li) begin
          if (sel) begin
            mode4 = m; duty4 = d[3:0]; load4 = 1'b1;
          end else begin
            mode8 = m; duty8 = d; load8 = 1'b1;
          end
        end
      end
      if (exp_q.size() == 0) begin
        chk({cur_test, " queue_empty"}, 0, 1);
        ev = '0;
      end else begin
        ev = exp_q.pop_front();
      end
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("%s p%0d ch%0d high", cur_test, p, c), hi[c], int'(ev[c*16 +: 16]));
        chk($sformatf("%s p%0d ch%0d lead", cur_test, p, c), run[c], int'(ev[c*16 +: 16]));
      end
      chk($sformatf("%s p%0d strobe_cnt", cur_test, p), sc, 1);
      chk($sformatf("%s p%0d strobe_end", cur_test, p), int'(last_s), 1);
    end
  endtask

  initial begin
    int env;
    rst_n = 1'b0;
    load8 = 1'b0; mode8 = 2'd0; duty8 = '0;
    load4 = 1'b0; mode4 = 2'd0; duty4 = '0;
    sel   = 1'b0;

    // Reset state
    cur_test = "reset";
    repeat (3) @(negedge clk);
    chk("reset led8", int'(led8), 0);
    chk("reset strobe8", int'(strobe8), 0);
    chk("reset led4", int'(led4), 0);
    chk("reset strobe4", int'(strobe4), 0);
    rst_n = 1'b1;

    // Static duties 0 / 64 / 255
    cur_test = "static8";
    @(negedge clk);
    mode8 = 2'd1; duty8 = {8'd255, 8'd64, 8'd0}; load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    sync_strobe();
    repeat (3) push_exp(0, 64, 255);
    run_periods(3, -1, 0, 2'd0, '0);

    // Mid-period load applies at the next boundary only
    cur_test = "midload";
    push_exp(0, 64, 255);
    push_exp(10, 20, 30);
    run_periods(2, 0, 100, 2'd1, {8'd30, 8'd20, 8'd10});

    // Load on the boundary cycle lands one period later
    cur_test = "bload";
    push_exp(10, 20, 30);
    push_exp(10, 20, 30);
    push_exp(200, 100, 50);
    run_periods(3, 0, 254, 2'd1, {8'd50, 8'd100, 8'd200});

    // Blink, two periods on / two off, starting on
    cur_test = "blink";
    push_exp(200, 100, 50);
    push_exp(128, 128, 128);
    push_exp(128, 128, 128);
    push_exp(0, 0, 0);
    push_exp(0, 0, 0);
    push_exp(128, 128, 128);
    run_periods(6, 0, 50, 2'd2, {3{8'd128}});

    // Reset mid-period while blinking
    cur_test = "midreset";
    repeat (50) @(negedge clk);
    chk("midreset led_before", int'(led8), 7);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset led8", int'(led8), 0);
    chk("midreset strobe8", int'(strobe8), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sync_strobe();
    push_exp(0, 0, 0);
    push_exp(0, 0, 0);
    run_periods(2, -1, 0, 2'd0, '0);
    cur_test = "postreset";
    push_exp(0, 0, 0);
    push_exp(1, 2, 3);
    run_periods(2, 0, 10, 2'd1, {8'd3, 8'd2, 8'd1});

    // Prescale 3, 4-bit counter: duty 5 is 15 high cycles of 48
    sel = 1'b1;
    cur_test = "prescale";
    sync_strobe();
    push_exp(0, 0, 0);
    push_exp(15, 0, 0);
    push_exp(15, 0, 0);
    run_periods(3, 0, 5, 2'd1, 24'd5);

    // Breathe, duty 15: triangle envelope 0..15..0 over 30 periods
    cur_test = "breathe";
    push_exp(15, 0, 0);
    for (int p = 0; p < 31; p++) begin
      env = ((p % 30) <= 15) ? (p % 30) : (30 - (p % 30));
      push_exp(3 * ((15 * env) >> 4), 0, 0);
    end
    run_periods(32, 0, 5, 2'd3, 24'd15);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pwm_seq.md
# led_pwm_seq

Parametrised multi-channel LED PWM sequencer driving per-channel active-high LED enables from one clock domain, directly fed by the internal oscillator clock at chip level. Per-channel duty and a shared mode (off, static, blink, breathe) are written through a double-buffered load port and applied atomically at PWM period boundaries, so LEDs never glitch mid-period. Replaces the fixed RGB LED driver with generic width, channel count and animated modes; output polarity inversion stays at chip level.

## Interface
- CHANNELS, 3: number of LED channels (≥1).
- PWM_WIDTH, 8: PWM counter/duty width W (2..16).
- PRESCALE, 1: clock cycles per PWM count (≥1).
- BLINK_PERIODS, 64: PWM periods per blink half-phase (≥1).
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_load  in  1  one-cycle strobe; captures i_duty and i_mode into shadow registers.
- i_mode  in  2  0 off, 1 static, 2 blink, 3 breathe.
- i_duty  in  CHANNELS*W  channel c duty in bits [c*W +: W].
- o_led  out  CHANNELS  registered LED enables, active-high.
- o_period_strobe  out  1  registered one-cycle pulse at each period boundary.

## Operation
- Prescaler counts 0..PRESCALE-1; tick when at PRESCALE-1 (PRESCALE=1: tick every cycle).
- PWM counter cnt (W bits) increments on tick; boundary event B = tick && cnt == 2^W-1; cnt wraps to 0.
- Shadow regs (duty ×CHANNELS, mode) load on i_load; repeated loads within a period: last wins.
- On B: active duty/mode <= shadow (pre-edge value); o_period_strobe <= 1 (else 0).
- Mode change at B (shadow mode ≠ active mode): env <= 0, dir <= up, blink_cnt <= 0, phase <= 1; this overrides normal stepping on that edge.
- Otherwise on B: breathe: env steps ±1; at env == 2^W-1 next step goes down, at 0 goes up (sequence 0,1..MAX,MAX-1..0,1..; each value held one period). Blink: blink_cnt increments; at BLINK_PERIODS-1 it clears and phase toggles.
- Effective duty eff[c] (combinational from active regs): off 0; static duty[c]; blink phase ? duty[c] : 0; breathe (duty[c]*env) >> W (2W-bit product, upper W bits kept).
- o_led[c] <= (cnt < eff[c]). Duty 0 = always off; duty 2^W-1 = on 2^W-1 of 2^W counts (never fully on).

## Timing
- Reset (async assert, sync-safe deassert by top level): o_led = 0, o_period_strobe = 0, cnt = 0, prescaler = 0, shadow/active duty = 0, modes = off, env = 0, dir = up, blink_cnt = 0, phase = 1.
- Period = PRESCALE × 2^W cycles; B once per period.
- o_led lags cnt by one cycle; new active values affect o_led from the cycle after cnt first reads 0.
- i_load to effect: applied at the next B; i_load on the same cycle as B is applied at the following B (one period later).
- Reset mid-period: all state cleared immediately; no partial period finishes.
- o_period_strobe is high during the cycle cnt == 0 following B.

## Test plan
- W=8, PRESCALE=1, load static duty {0,64,255}: each period o_led[0] never high, o_led[1] high exactly 64 consecutive cycles, o_led[2] high 255, low 1; strobe every 256 cycles.
- Load at mid-period, then load same cycle as B: outputs change only at first B after load; the B-coincident load takes effect one period later.
- Blink, BLINK_PERIODS=2, duty 128: pattern on 2 periods / off 2 periods, starting on at the applying boundary.
- Breathe, W=4, duty 15: env 0..15..0 over 30 periods; eff at env 15 = 14; period of env 0 has o_led low throughout.
- PRESCALE=3, W=4: period 48 cycles; duty 5 gives 15 high cycles.
- Assert i_rst_n low mid-period in blink mode: o_led and strobe go 0 immediately; after release mode off until new load applies.
